// File: rtl/tri_setup_unit.sv
// tri_setup_unit: triangle setup producing the rasterizer descriptor.
// The descriptor carries the bbox, edge functions, edge and depth increments, and top-left flags.
module tri_setup_unit #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [191:0] s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  output logic [511:0] m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic         m_axis_tlast,
  output logic         tri_dropped
);
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_EDGE, S_DIVX, S_DIVY, S_ZROW, S_OUT} state_t;
  localparam logic signed [15:0] XMAX = 16'(SCREEN_W - 1);
  localparam logic signed [15:0] YMAX = 16'(SCREEN_H - 1);

  function automatic logic signed [31:0] edge_fn(input logic signed [15:0] ax, ay, bx, by, px, py);
    return (32'(bx) - 32'(ax)) * (32'(py) - 32'(ay)) - (32'(by) - 32'(ay)) * (32'(px) - 32'(ax));
  endfunction

  function automatic logic signed [15:0] min3(input logic signed [15:0] a, b, c);
    logic signed [15:0] m;
    m = a < b ? a : b;
    return m < c ? m : c;
  endfunction

  function automatic logic signed [15:0] max3(input logic signed [15:0] a, b, c);
    logic signed [15:0] m;
    m = a > b ? a : b;
    return m > c ? m : c;
  endfunction

  function automatic logic signed [31:0] sat(input logic [63:0] mag, input logic neg);
    if (neg) return mag > 64'h8000_0000 ? 32'sh8000_0000 : -mag[31:0];
    return mag > 64'h7fff_ffff ? 32'sh7fff_ffff : mag[31:0];
  endfunction

  state_t r_state, w_next;
  logic signed [15:0] r_x [3];
  logic signed [15:0] r_y [3];
  logic signed [31:0] r_z [3];
  logic signed [15:0] r_minx, r_miny, r_maxx, r_maxy;
  logic signed [31:0] r_area2, r_zdx, r_zdy;
  logic signed [31:0] r_e [3];
  logic signed [31:0] r_edx [3];
  logic signed [31:0] r_edy [3];
  logic [2:0]   r_flags;
  logic [63:0]  r_ny_mag, r_quo;
  logic         r_ny_neg, r_neg, r_tvalid;
  logic [31:0]  r_rem, r_den;
  logic [5:0]   r_cnt;
  logic [511:0] r_tdata;

  logic signed [15:0] w_minx, w_miny, w_maxx, w_maxy, w_lox, w_loy, w_hix, w_hiy;
  logic signed [31:0] w_area2, w_zrow;
  logic signed [31:0] w_e [3];
  logic signed [31:0] w_edx [3];
  logic signed [31:0] w_edy [3];
  logic [2:0]   w_flags;
  logic         w_drop, w_neg_area, w_ge;
  logic signed [63:0] w_dz1, w_dz2, w_dx1, w_dx2, w_dy1, w_dy2, w_nx, w_ny;
  logic [63:0]  w_nx_mag, w_ny_mag, w_quo;
  logic [31:0]  w_den, w_rem;
  logic [32:0]  w_sh;
  logic [511:0] w_desc;

  // min is only clamped from below and max from above, so an off-screen box stays empty
  assign w_lox   = min3(r_x[0], r_x[1], r_x[2]);
  assign w_loy   = min3(r_y[0], r_y[1], r_y[2]);
  assign w_hix   = max3(r_x[0], r_x[1], r_x[2]);
  assign w_hiy   = max3(r_y[0], r_y[1], r_y[2]);
  assign w_minx  = w_lox < 16'sd0 ? 16'sd0 : w_lox;
  assign w_miny  = w_loy < 16'sd0 ? 16'sd0 : w_loy;
  assign w_maxx  = w_hix > XMAX ? XMAX : w_hix;
  assign w_maxy  = w_hiy > YMAX ? YMAX : w_hiy;
  assign w_area2 = edge_fn(r_x[1], r_y[1], r_x[2], r_y[2], r_x[0], r_y[0]);
  assign w_drop  = w_area2 == 32'sd0 || w_minx > w_maxx || w_miny > w_maxy;

  assign w_neg_area = r_area2 < 32'sd0;
  for (genvar g = 0; g < 3; g++) begin : g_edge
    localparam int A = (g + 1) % 3;
    localparam int B = (g + 2) % 3;
    logic signed [31:0] w_re, w_rdx, w_rdy;
    assign w_re       = edge_fn(r_x[A], r_y[A], r_x[B], r_y[B], r_minx, r_miny);
    assign w_rdx      = 32'(r_y[A]) - 32'(r_y[B]);
    assign w_rdy      = 32'(r_x[B]) - 32'(r_x[A]);
    assign w_e[g]     = w_neg_area ? -w_re : w_re;
    assign w_edx[g]   = w_neg_area ? -w_rdx : w_rdx;
    assign w_edy[g]   = w_neg_area ? -w_rdy : w_rdy;
    assign w_flags[g] = w_edx[g] > 32'sd0 || (w_edx[g] == 32'sd0 && w_edy[g] > 32'sd0);
  end

  assign w_dz1    = 64'(r_z[1]) - 64'(r_z[0]);
  assign w_dz2    = 64'(r_z[2]) - 64'(r_z[0]);
  assign w_dx1    = 64'(r_x[1]) - 64'(r_x[0]);
  assign w_dx2    = 64'(r_x[2]) - 64'(r_x[0]);
  assign w_dy1    = 64'(r_y[1]) - 64'(r_y[0]);
  assign w_dy2    = 64'(r_y[2]) - 64'(r_y[0]);
  assign w_nx     = w_dz1 * w_dy2 - w_dz2 * w_dy1;
  assign w_ny     = w_dz2 * w_dx1 - w_dz1 * w_dx2;
  assign w_nx_mag = w_nx < 64'sd0 ? -w_nx : w_nx;
  assign w_ny_mag = w_ny < 64'sd0 ? -w_ny : w_ny;
  assign w_den    = w_neg_area ? -r_area2 : r_area2;

  // restoring divider: remainder stays below the divisor, so 32 bits plus the shifted-in bit suffice
  assign w_sh  = {r_rem, r_quo[63]};
  assign w_ge  = w_sh >= {1'b0, r_den};
  assign w_rem = w_ge ? 32'(w_sh - {1'b0, r_den}) : w_sh[31:0];
  assign w_quo = {r_quo[62:0], w_ge};

  assign w_zrow = r_z[0] + r_zdx * (32'(r_minx) - 32'(r_x[0])) + r_zdy * (32'(r_miny) - 32'(r_y[0]));
  assign w_desc = {61'd0, r_flags, r_zdy, r_zdx, w_zrow,
                   r_edy[2], r_edy[1], r_edy[0], r_edx[2], r_edx[1], r_edx[0],
                   r_e[2], r_e[1], r_e[0], r_maxy, r_maxx, r_miny, r_minx};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = s_axis_tvalid ? S_SETUP : S_IDLE;
      S_SETUP: w_next = w_drop ? S_IDLE : S_EDGE;
      S_EDGE:  w_next = S_DIVX;
      S_DIVX:  w_next = &r_cnt ? S_DIVY : S_DIVX;
      S_DIVY:  w_next = &r_cnt ? S_ZROW : S_DIVY;
      S_ZROW:  w_next = S_OUT;
      S_OUT:   w_next = m_axis_tready ? S_IDLE : S_OUT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x      <= '{default: '0};
      r_y      <= '{default: '0};
      r_z      <= '{default: '0};
      r_e      <= '{default: '0};
      r_edx    <= '{default: '0};
      r_edy    <= '{default: '0};
      r_minx   <= '0;
      r_miny   <= '0;
      r_maxx   <= '0;
      r_maxy   <= '0;
      r_area2  <= '0;
      r_zdx    <= '0;
      r_zdy    <= '0;
      r_flags  <= '0;
      r_ny_mag <= '0;
      r_ny_neg <= 1'b0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_den    <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (s_axis_tvalid) begin
          r_x[0] <= s_axis_tdata[15:0];
          r_y[0] <= s_axis_tdata[31:16];
          r_z[0] <= s_axis_tdata[63:32];
          r_x[1] <= s_axis_tdata[79:64];
          r_y[1] <= s_axis_tdata[95:80];
          r_z[1] <= s_axis_tdata[127:96];
          r_x[2] <= s_axis_tdata[143:128];
          r_y[2] <= s_axis_tdata[159:144];
          r_z[2] <= s_axis_tdata[191:160];
        end
        S_SETUP: begin
          r_minx  <= w_minx;
          r_miny  <= w_miny;
          r_maxx  <= w_maxx;
          r_maxy  <= w_maxy;
          r_area2 <= w_area2;
        end
        S_EDGE: begin
          r_e      <= w_e;
          r_edx    <= w_edx;
          r_edy    <= w_edy;
          r_flags  <= w_flags;
          r_quo    <= w_nx_mag;
          r_rem    <= '0;
          r_den    <= w_den;
          r_neg    <= (w_nx < 64'sd0) ^ w_neg_area;
          r_ny_mag <= w_ny_mag;
          r_ny_neg <= (w_ny < 64'sd0) ^ w_neg_area;
          r_cnt    <= '0;
        end
        S_DIVX: begin
          r_cnt <= r_cnt + 6'd1;
          if (&r_cnt) begin
            r_zdx <= sat(w_quo, r_neg);
            r_quo <= r_ny_mag;
            r_rem <= '0;
            r_neg <= r_ny_neg;
          end else begin
            r_quo <= w_quo;
            r_rem <= w_rem;
          end
        end
        S_DIVY: begin
          r_cnt <= r_cnt + 6'd1;
          r_quo <= w_quo;
          r_rem <= w_rem;
          if (&r_cnt) r_zdy <= sat(w_quo, r_neg);
        end
        S_ZROW: begin
          r_tdata  <= w_desc;
          r_tvalid <= 1'b1;
        end
        S_OUT: if (m_axis_tready) r_tvalid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign s_axis_tready = r_state == S_IDLE;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tvalid;
  assign tri_dropped   = r_state == S_SETUP && w_drop;
endmodule
